// File: rtl/imem_boot_loader.sv
// -----------------------------------------------------------------------------
// imem_boot_loader
//   Loads a program image into instruction memory from a byte stream and holds
//   the core stalled until the image is complete.
//
//   Stream format: 4-byte little-endian word count N, then N 32-bit
//   little-endian instruction words. Words are written to sequential word
//   addresses starting at 0. A bad header (N == 0 or N > MEM_SIZE) or a stall
//   in the stream longer than TIMEOUT_CYCLES parks the loader in an error
//   state until the next Load_Req.
//
// Ports
//   Clk_Core      in   core clock, rising-edge
//   Rst_Core_N    in   asynchronous active-low reset
//   Load_Req      in   1-cycle pulse, starts a load from IDLE/RUN/ERR
//   Byte_Data     in   stream byte
//   Byte_Valid    in   stream byte valid
//   Byte_Ready    out  loader accepts a byte (HDR/DATA)
//   Mem_Wr_En     out  1-cycle instruction memory write strobe
//   Mem_Wr_Addr   out  word address of the write
//   Mem_Wr_Data   out  instruction word being written
//   Core_Stall    out  core must not fetch / advance PC
//   Load_Busy     out  header or data phase in progress
//   Load_Err      out  loader is in the error state
//   Words_Loaded  out  words written by the current/last load
// -----------------------------------------------------------------------------
module imem_boot_loader #(
  parameter int MEM_SIZE       = 128,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int ADDR_SIZE     = $clog2(MEM_SIZE)
) (
  input  logic                 Clk_Core,
  input  logic                 Rst_Core_N,
  input  logic                 Load_Req,
  input  logic [7:0]           Byte_Data,
  input  logic                 Byte_Valid,
  output logic                 Byte_Ready,
  output logic                 Mem_Wr_En,
  output logic [ADDR_SIZE-1:0] Mem_Wr_Addr,
  output logic [31:0]          Mem_Wr_Data,
  output logic                 Core_Stall,
  output logic                 Load_Busy,
  output logic                 Load_Err,
  output logic [ADDR_SIZE:0]   Words_Loaded
);

  // The timer only ever needs to hold 0 .. TIMEOUT_CYCLES-1: the edge that
  // would take it to TIMEOUT_CYCLES leaves HDR/DATA instead.
  localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST   = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0]      MEM_SIZE_W = 32'(MEM_SIZE);
  localparam logic [ADDR_SIZE:0] WORDS_ONE = {{ADDR_SIZE{1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
    S_RUN,
    S_ERR
  } state_t;

  state_t               state;
  state_t               state_nxt;

  logic [1:0]           byte_cnt;
  logic [23:0]          asm_q;      // bytes 0..2 of the word being assembled
  logic [ADDR_SIZE:0]   word_cnt;   // N from the header
  logic [TMR_W-1:0]     timer;

  logic                 in_stream;
  logic                 byte_acc;
  logic                 word_done;
  logic [31:0]          asm_word;
  logic                 hdr_bad;
  logic [ADDR_SIZE:0]   words_inc;
  logic                 last_word;
  logic                 timeout_hit;
  logic                 start_load;

  assign in_stream  = (state == S_HDR) || (state == S_DATA);
  assign byte_acc   = in_stream && Byte_Valid;
  assign word_done  = byte_acc && (byte_cnt == 2'd3);
  assign asm_word   = {Byte_Data, asm_q};
  // Full 32-bit compare: upper header bits must not alias into range.
  assign hdr_bad    = (asm_word == 32'd0) || (asm_word > MEM_SIZE_W);
  assign words_inc  = Words_Loaded + WORDS_ONE;
  assign last_word  = (words_inc == word_cnt);
  // An accepted byte on the expiry edge wins over the timeout.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && in_stream && !byte_acc &&
                       (timer == TMR_LAST);
  assign start_load = Load_Req &&
                      ((state == S_IDLE) || (state == S_RUN) || (state == S_ERR));

  // State register
  always_ff @(posedge Clk_Core or negedge Rst_Core_N) begin
    if (!Rst_Core_N) state <= S_IDLE;
    else             state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_RUN, S_ERR: begin
        if (Load_Req) state_nxt = S_HDR;
      end
      S_HDR: begin
        if (word_done)        state_nxt = hdr_bad ? S_ERR : S_DATA;
        else if (timeout_hit) state_nxt = S_ERR;
      end
      S_DATA: begin
        if (word_done && last_word) state_nxt = S_RUN;
        else if (timeout_hit)       state_nxt = S_ERR;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Decoded outputs
  always_comb begin
    Byte_Ready = in_stream;
    Load_Busy  = in_stream;
    Load_Err   = (state == S_ERR);
  end

  // Registered datapath and outputs
  always_ff @(posedge Clk_Core or negedge Rst_Core_N) begin
    if (!Rst_Core_N) begin
      byte_cnt     <= 2'd0;
      asm_q        <= 24'd0;
      word_cnt     <= '0;
      timer        <= '0;
      Mem_Wr_En    <= 1'b0;
      Mem_Wr_Addr  <= '0;
      Mem_Wr_Data  <= 32'd0;
      Core_Stall   <= 1'b1;
      Words_Loaded <= '0;
    end else begin
      Mem_Wr_En <= 1'b0;
      if (start_load) begin
        byte_cnt     <= 2'd0;
        Words_Loaded <= '0;
        timer        <= '0;
        Core_Stall   <= 1'b1;
      end else if (in_stream) begin
        if (byte_acc) begin
          timer    <= '0;
          byte_cnt <= byte_cnt + 2'd1;
          case (byte_cnt)
            2'd0: asm_q[7:0]   <= Byte_Data;
            2'd1: asm_q[15:8]  <= Byte_Data;
            2'd2: asm_q[23:16] <= Byte_Data;
            default: begin
              if (state == S_HDR) begin
                word_cnt <= asm_word[ADDR_SIZE:0];
              end else begin
                Mem_Wr_En    <= 1'b1;
                Mem_Wr_Addr  <= Words_Loaded[ADDR_SIZE-1:0];
                Mem_Wr_Data  <= asm_word;
                Words_Loaded <= words_inc;
                if (last_word) Core_Stall <= 1'b0;
              end
            end
          endcase
        end else if (TIMEOUT_CYCLES != 0) begin
          timer <= timer + {{(TMR_W-1){1'b0}}, 1'b1};
        end
      end
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
module tb_imem_boot_loader;

  localparam int MEM_SIZE  = 16;
  localparam int TIMEOUT   = 16;
  localparam int ADDR_SIZE = $clog2(MEM_SIZE);

  logic                 Clk_Core;
  logic                 Rst_Core_N;
  logic                 Load_Req;
  logic [7:0]           Byte_Data;
  logic                 Byte_Valid;
  logic                 Byte_Ready;
  logic                 Mem_Wr_En;
  logic [ADDR_SIZE-1:0] Mem_Wr_Addr;
  logic [31:0]          Mem_Wr_Data;
  logic                 Core_Stall;
  logic                 Load_Busy;
  logic                 Load_Err;
  logic [ADDR_SIZE:0]   Words_Loaded;

  int checks   = 0;
  int failures = 0;

  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];

  typedef struct {
    logic [31:0] n;
    logic        exp_err;
  } hdr_vec_t;

  hdr_vec_t vecs[7];

  imem_boot_loader #(
    .MEM_SIZE       (MEM_SIZE),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .Clk_Core     (Clk_Core),
    .Rst_Core_N   (Rst_Core_N),
    .Load_Req     (Load_Req),
    .Byte_Data    (Byte_Data),
    .Byte_Valid   (Byte_Valid),
    .Byte_Ready   (Byte_Ready),
    .Mem_Wr_En    (Mem_Wr_En),
    .Mem_Wr_Addr  (Mem_Wr_Addr),
    .Mem_Wr_Data  (Mem_Wr_Data),
    .Core_Stall   (Core_Stall),
    .Load_Busy    (Load_Busy),
    .Load_Err     (Load_Err),
    .Words_Loaded (Words_Loaded)
  );

  initial Clk_Core = 1'b0;
  always #5 Clk_Core = ~Clk_Core;

  // Capture every memory write strobe, sampled mid-cycle.
  always @(negedge Clk_Core) begin
    if (Mem_Wr_En === 1'b1) begin
      wa_q.push_back(32'(Mem_Wr_Addr));
      wd_q.push_back(Mem_Wr_Data);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic check_write(input string name, input logic [31:0] ea, input logic [31:0] ed);
    logic [31:0] a, d;
    check({name, "_present"}, 32'(wa_q.size() != 0), 32'd1);
    if (wa_q.size() != 0) begin
      a = wa_q.pop_front();
      d = wd_q.pop_front();
      check({name, "_addr"}, a, ea);
      check({name, "_data"}, d, ed);
    end
  endtask

  task automatic check_reset_vals(input string name);
    check({name, "_stall"}, 32'(Core_Stall),   32'd1);
    check({name, "_ready"}, 32'(Byte_Ready),   32'd0);
    check({name, "_wren"},  32'(Mem_Wr_En),    32'd0);
    check({name, "_busy"},  32'(Load_Busy),    32'd0);
    check({name, "_err"},   32'(Load_Err),     32'd0);
    check({name, "_addr"},  32'(Mem_Wr_Addr),  32'd0);
    check({name, "_data"},  Mem_Wr_Data,       32'd0);
    check({name, "_words"}, 32'(Words_Loaded), 32'd0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge Clk_Core);
    Byte_Data  = b;
    Byte_Valid = 1'b1;
    while (Byte_Ready !== 1'b1 && n < 40) begin
      @(negedge Clk_Core);
      n++;
    end
    if (Byte_Ready !== 1'b1) begin
      check("byte_ready_wait", 32'(Byte_Ready), 32'd1);
      Byte_Valid = 1'b0;
    end else begin
      @(posedge Clk_Core);
      #1 Byte_Valid = 1'b0;
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[7:0]);
    send_byte(w[15:8]);
    send_byte(w[23:16]);
    send_byte(w[31:24]);
  endtask

  task automatic pulse_load();
    @(negedge Clk_Core);
    Load_Req = 1'b1;
    @(negedge Clk_Core);
    Load_Req = 1'b0;
  endtask

  function automatic logic [31:0] img_word(input int i);
    return 32'hA5000000 | (32'(i) << 16) | (32'(i) << 8) | 32'(8'hF0 - i);
  endfunction

  initial begin
    vecs[0] = '{n: 32'h00000000, exp_err: 1'b1};
    vecs[1] = '{n: 32'h00000001, exp_err: 1'b0};
    vecs[2] = '{n: 32'h00000010, exp_err: 1'b0};  // N == MEM_SIZE
    vecs[3] = '{n: 32'h00000011, exp_err: 1'b1};  // N == MEM_SIZE+1
    vecs[4] = '{n: 32'h00000101, exp_err: 1'b1};  // low bits look legal
    vecs[5] = '{n: 32'h80000001, exp_err: 1'b1};
    vecs[6] = '{n: 32'h0000000F, exp_err: 1'b0};

    Rst_Core_N = 1'b1;
    Load_Req   = 1'b0;
    Byte_Data  = 8'h00;
    Byte_Valid = 1'b0;
    #1 Rst_Core_N = 1'b0;
    repeat (2) @(negedge Clk_Core);
    check_reset_vals("reset");
    Rst_Core_N = 1'b1;

    // IDLE ignores the stream
    Byte_Valid = 1'b1;
    repeat (2) @(negedge Clk_Core);
    check("idle_ready", 32'(Byte_Ready), 32'd0);
    check("idle_busy",  32'(Load_Busy),  32'd0);
    Byte_Valid = 1'b0;

    // Basic two-word load
    pulse_load();
    check("t1_busy",  32'(Load_Busy),    32'd1);
    check("t1_stall", 32'(Core_Stall),   32'd1);
    check("t1_ready", 32'(Byte_Ready),   32'd1);
    send_word(32'd2);
    send_word(32'h00000013);
    @(negedge Clk_Core);
    check("t1_w0_wren",  32'(Mem_Wr_En),    32'd1);
    check("t1_w0_stall", 32'(Core_Stall),   32'd1);
    check("t1_w0_words", 32'(Words_Loaded), 32'd1);
    send_word(32'h00100093);
    @(negedge Clk_Core);
    check("t1_last_wren",  32'(Mem_Wr_En),    32'd1);
    check("t1_last_stall", 32'(Core_Stall),   32'd0);
    check("t1_last_words", 32'(Words_Loaded), 32'd2);
    check("t1_last_busy",  32'(Load_Busy),    32'd0);
    check("t1_last_ready", 32'(Byte_Ready),   32'd0);
    @(negedge Clk_Core);
    check("t1_wren_drop", 32'(Mem_Wr_En),  32'd0);
    check("t1_run_stall", 32'(Core_Stall), 32'd0);
    check_write("t1_wr0", 32'd0, 32'h00000013);
    check_write("t1_wr1", 32'd1, 32'h00100093);

    // Reload from RUN
    pulse_load();
    check("t5_stall",  32'(Core_Stall),   32'd1);
    check("t5_words",  32'(Words_Loaded), 32'd0);
    check("t5_busy",   32'(Load_Busy),    32'd1);
    send_word(32'd1);
    send_word(32'hDEADBEEF);
    @(negedge Clk_Core);
    check("t5_run_stall", 32'(Core_Stall),   32'd0);
    check("t5_run_words", 32'(Words_Loaded), 32'd1);
    @(negedge Clk_Core);
    check_write("t5_wr0", 32'd0, 32'hDEADBEEF);

    // Header table: bad headers go to ERR at once, good ones time out in DATA
    pulse_load();
    for (int i = 0; i < 7; i++) begin
      send_word(vecs[i].n);
      @(negedge Clk_Core);
      check($sformatf("hdr%0d_err",   i), 32'(Load_Err),   32'(vecs[i].exp_err));
      check($sformatf("hdr%0d_busy",  i), 32'(Load_Busy),  32'(!vecs[i].exp_err));
      check($sformatf("hdr%0d_stall", i), 32'(Core_Stall), 32'd1);
      if (!vecs[i].exp_err) begin
        repeat (20) @(negedge Clk_Core);
        check($sformatf("hdr%0d_tmo_err", i), 32'(Load_Err), 32'd1);
      end
      check($sformatf("hdr%0d_ready", i), 32'(Byte_Ready),   32'd0);
      check($sformatf("hdr%0d_words", i), 32'(Words_Loaded), 32'd0);
      pulse_load();
      check($sformatf("hdr%0d_reload_err",  i), 32'(Load_Err),  32'd0);
      check($sformatf("hdr%0d_reload_busy", i), 32'(Load_Busy), 32'd1);
    end
    @(negedge Clk_Core);
    check("hdr_no_writes", 32'(wa_q.size()), 32'd0);

    // Full-memory image (already in HDR)
    send_word(32'(MEM_SIZE));
    for (int i = 0; i < MEM_SIZE; i++) send_word(img_word(i));
    @(negedge Clk_Core);
    check("full_words", 32'(Words_Loaded), 32'd16);
    check("full_stall", 32'(Core_Stall),   32'd0);
    check("full_addr",  32'(Mem_Wr_Addr),  32'd15);
    check("full_busy",  32'(Load_Busy),    32'd0);
    @(negedge Clk_Core);
    for (int i = 0; i < MEM_SIZE; i++)
      check_write($sformatf("full_wr%0d", i), 32'(i), img_word(i));

    // Timeout: accept on the expiry edge survives, then a real stall expires
    pulse_load();
    send_word(32'd3);
    send_byte(8'h11);
    repeat (15) @(posedge Clk_Core);
    send_byte(8'h22);
    @(negedge Clk_Core);
    check("tmo_race_busy", 32'(Load_Busy), 32'd1);
    check("tmo_race_err",  32'(Load_Err),  32'd0);
    send_byte(8'h33);
    send_byte(8'h44);
    send_byte(8'h55);
    send_byte(8'h66);
    repeat (15) @(posedge Clk_Core);
    @(negedge Clk_Core);
    check("tmo_15_busy", 32'(Load_Busy), 32'd1);
    check("tmo_15_err",  32'(Load_Err),  32'd0);
    @(posedge Clk_Core);
    @(negedge Clk_Core);
    check("tmo_16_err",   32'(Load_Err),     32'd1);
    check("tmo_16_words", 32'(Words_Loaded), 32'd1);
    check("tmo_16_ready", 32'(Byte_Ready),   32'd0);
    check("tmo_16_stall", 32'(Core_Stall),   32'd1);
    Byte_Valid = 1'b1;
    repeat (5) @(negedge Clk_Core);
    Byte_Valid = 1'b0;
    check("tmo_frozen_words", 32'(Words_Loaded), 32'd1);
    check("tmo_frozen_err",   32'(Load_Err),     32'd1);
    check_write("tmo_wr0", 32'd0, 32'h44332211);
    check("tmo_no_more_writes", 32'(wa_q.size()), 32'd0);

    // Async reset in the middle of DATA
    pulse_load();
    send_word(32'd2);
    send_byte(8'h01);
    send_byte(8'h02);
    @(negedge Clk_Core);
    check("mid_busy", 32'(Load_Busy), 32'd1);
    #2 Rst_Core_N = 1'b0;
    #1;
    check_reset_vals("async_rst");
    @(negedge Clk_Core);
    Rst_Core_N = 1'b1;
    repeat (3) @(negedge Clk_Core);
    check("post_rst_busy",  32'(Load_Busy),  32'd0);
    check("post_rst_stall", 32'(Core_Stall), 32'd1);
    check("post_rst_writes", 32'(wa_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
